// File: rtl/sound_pkg.sv
// Shared constants for the speaker tone path: note codes, requester ids,
// pattern lengths and the scheduler state encoding.
package sound_pkg;

    localparam logic [7:0] OCTAVE  = 8'd12;
    localparam logic [7:0] NOTE_A  = 8'd0;
    localparam logic [7:0] NOTE_AS = 8'd1;
    localparam logic [7:0] NOTE_B  = 8'd2;
    localparam logic [7:0] NOTE_C  = 8'd3;
    localparam logic [7:0] NOTE_CS = 8'd4;
    localparam logic [7:0] NOTE_D  = 8'd5;
    localparam logic [7:0] NOTE_DS = 8'd6;
    localparam logic [7:0] NOTE_E  = 8'd7;
    localparam logic [7:0] NOTE_F  = 8'd8;
    localparam logic [7:0] NOTE_FS = 8'd9;
    localparam logic [7:0] NOTE_G  = 8'd10;
    localparam logic [7:0] NOTE_GS = 8'd11;

    localparam logic [7:0] ALARM_HI  = 8'd5 * OCTAVE + NOTE_A;
    localparam logic [7:0] ALARM_LO  = 8'd4 * OCTAVE + NOTE_E;
    localparam logic [7:0] FAIL_NOTE = 8'd2 * OCTAVE + NOTE_C;
    localparam logic [7:0] CHIME_0   = 8'd3 * OCTAVE + NOTE_C;
    localparam logic [7:0] CHIME_1   = 8'd3 * OCTAVE + NOTE_E;
    localparam logic [7:0] CHIME_2   = 8'd3 * OCTAVE + NOTE_G;
    localparam logic [7:0] CHIME_3   = 8'd4 * OCTAVE + NOTE_C;

    localparam logic [1:0] SND_ALARM = 2'd0;
    localparam logic [1:0] SND_FAIL  = 2'd1;
    localparam logic [1:0] SND_CHIME = 2'd2;

    localparam int unsigned ALARM_LEN = 8;
    localparam int unsigned FAIL_LEN  = 2;
    localparam int unsigned CHIME_LEN = 4;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    function automatic logic [2:0] last_step(input logic [1:0] id);
        case (id)
            SND_ALARM: last_step = 3'(ALARM_LEN - 1);
            SND_FAIL:  last_step = 3'(FAIL_LEN - 1);
            SND_CHIME: last_step = 3'(CHIME_LEN - 1);
            default:   last_step = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/sound_pattern_rom.sv
// Fixed note patterns: (requester id, step) -> note code and last-step flag.
module sound_pattern_rom
    import sound_pkg::*;
(
    input  logic [1:0] id,
    input  logic [2:0] step,
    output logic [7:0] note,
    output logic       last
);

    always_comb begin
        note = '0;
        case (id)
            SND_ALARM: note = step[0] ? ALARM_LO : ALARM_HI;
            SND_FAIL:  note = (step <= last_step(SND_FAIL)) ? FAIL_NOTE : '0;
            SND_CHIME: begin
                case (step)
                    3'd0:    note = CHIME_0;
                    3'd1:    note = CHIME_1;
                    3'd2:    note = CHIME_2;
                    3'd3:    note = CHIME_3;
                    default: note = '0;
                endcase
            end
            default:   note = '0;
        endcase
    end

    assign last = (step >= last_step(id));

endmodule

// File: rtl/sound_scheduler.sv
// Priority arbiter and note sequencer for the tone generator.
// Define SOUND_SCHED_REPEAT_EN to make the alarm pattern loop until cancelled.
module sound_scheduler
    import sound_pkg::*;
#(
    parameter int unsigned NOTE_TICKS = 12_500_000,
    parameter int unsigned GAP_TICKS  = 1_250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       cancel,
    output logic [2:0] ack,
    output logic [2:0] done,
    output logic       busy,
    output logic [7:0] fullnote,
    output logic       tone_en
);

    localparam int unsigned MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS);
    localparam logic [CNT_W-1:0] NOTE_END = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_TICKS - 1);

    state_t           state, state_nxt;
    logic [1:0]       owner, owner_nxt, winner;
    logic [2:0]       step, step_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       ack_nxt, done_nxt;
    logic [7:0]       fullnote_nxt, cur_note, nxt_note;
    logic             cur_last, nxt_last;
    logic             unused_rom;

    // One lookup tells whether the current step is the last; the other
    // supplies the note for whatever will be playing after this edge.
    sound_pattern_rom u_rom_cur (.id(owner),     .step(step),     .note(cur_note), .last(cur_last));
    sound_pattern_rom u_rom_nxt (.id(owner_nxt), .step(step_nxt), .note(nxt_note), .last(nxt_last));

    assign unused_rom = ^{cur_note, nxt_last};

    always_comb begin
        winner    = req[0] ? SND_ALARM : (req[1] ? SND_FAIL : SND_CHIME);
        state_nxt = state;
        owner_nxt = owner;
        step_nxt  = step;
        cnt_nxt   = cnt;
        ack_nxt   = '0;
        done_nxt  = '0;
        if (cancel) begin
            state_nxt = IDLE;
            step_nxt  = '0;
            cnt_nxt   = '0;
        end else if ((|req) && (state == IDLE || winner < owner)) begin
            state_nxt = PLAY;
            owner_nxt = winner;
            step_nxt  = '0;
            cnt_nxt   = '0;
            ack_nxt   = 3'b001 << winner;
        end else begin
            case (state)
                PLAY: begin
                    if (cnt == NOTE_END) begin
                        state_nxt = GAP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_END) begin
                        cnt_nxt = '0;
                        if (!cur_last) begin
                            state_nxt = PLAY;
                            step_nxt  = step + 3'd1;
                        end
`ifdef SOUND_SCHED_REPEAT_EN
                        else if (owner == SND_ALARM) begin
                            state_nxt = PLAY;
                            step_nxt  = '0;
                        end
`endif
                        else begin
                            state_nxt = IDLE;
                            step_nxt  = '0;
                            done_nxt  = 3'b001 << owner;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fullnote_nxt = '0;
        if (state_nxt == PLAY)
            fullnote_nxt = nxt_note;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            step     <= '0;
            cnt      <= '0;
            ack      <= '0;
            done     <= '0;
            busy     <= 1'b0;
            fullnote <= '0;
            tone_en  <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            step     <= step_nxt;
            cnt      <= cnt_nxt;
            ack      <= ack_nxt;
            done     <= done_nxt;
            busy     <= (state_nxt != IDLE);
            fullnote <= fullnote_nxt;
            tone_en  <= (state_nxt == PLAY) && (fullnote_nxt != '0);
        end
    end

endmodule
